// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and bubble-count constants for the hazard controller
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  typedef logic [1:0] bubble_t;

  // Bubbles per producer stage: with forwarding only a load in EX costs a slot
  localparam bubble_t FWD_LOAD_BUBBLES = 2'd1;
  localparam bubble_t BYP_EX_BUBBLES   = 2'd2;
  localparam bubble_t BYP_MEM_BUBBLES  = 2'd1;
  localparam bubble_t BYP_WB_BUBBLES   = 2'd0;
  localparam bubble_t RAW_EX_BUBBLES   = 2'd3;
  localparam bubble_t RAW_MEM_BUBBLES  = 2'd2;
  localparam bubble_t RAW_WB_BUBBLES   = 2'd1;

  function automatic bubble_t max_bubble(input bubble_t a, input bubble_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_dist.sv
// rtl/hazard_dist.sv - combinational RAW match and worst-case bubble count for both sources
module hazard_dist
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 3,
  parameter int FORWARD_EN  = 1,
  parameter int RF_BYPASS   = 1,
  parameter int ZERO_REG_EN = 0
) (
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic              id_rs_vld_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_rt_vld_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_wr_en_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_wr_en_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_wr_en_i,
  output bubble_t           bubbles_o
);

  function automatic logic match(input logic [REG_AW-1:0] src, input logic vld,
                                 input logic [REG_AW-1:0] dst, input logic en);
    logic zero_dst;
    zero_dst = (ZERO_REG_EN != 0) && (dst == '0);
    return vld && en && (src == dst) && !zero_dst;
  endfunction

  // Nearer producers always cost more, so first match in EX/MEM/WB order is the maximum
  function automatic bubble_t stage_need(input logic hit_ex, input logic hit_mem,
                                         input logic hit_wb, input logic is_load);
    bubble_t n;
    n = '0;
    if (FORWARD_EN != 0) begin
      if (hit_ex && is_load) n = FWD_LOAD_BUBBLES;
    end else if (RF_BYPASS != 0) begin
      if (hit_ex)       n = BYP_EX_BUBBLES;
      else if (hit_mem) n = BYP_MEM_BUBBLES;
      else if (hit_wb)  n = BYP_WB_BUBBLES;
    end else begin
      if (hit_ex)       n = RAW_EX_BUBBLES;
      else if (hit_mem) n = RAW_MEM_BUBBLES;
      else if (hit_wb)  n = RAW_WB_BUBBLES;
    end
    return n;
  endfunction

  logic    rs_ex, rs_mem, rs_wb;
  logic    rt_ex, rt_mem, rt_wb;
  bubble_t rs_need, rt_need;

  assign rs_ex  = match(id_rs_i, id_rs_vld_i, ex_rd_i,  ex_wr_en_i);
  assign rs_mem = match(id_rs_i, id_rs_vld_i, mem_rd_i, mem_wr_en_i);
  assign rs_wb  = match(id_rs_i, id_rs_vld_i, wb_rd_i,  wb_wr_en_i);
  assign rt_ex  = match(id_rt_i, id_rt_vld_i, ex_rd_i,  ex_wr_en_i);
  assign rt_mem = match(id_rt_i, id_rt_vld_i, mem_rd_i, mem_wr_en_i);
  assign rt_wb  = match(id_rt_i, id_rt_vld_i, wb_rd_i,  wb_wr_en_i);

  assign rs_need   = stage_need(rs_ex, rs_mem, rs_wb, ex_is_load_i);
  assign rt_need   = stage_need(rt_ex, rt_mem, rt_wb, ex_is_load_i);
  assign bubbles_o = max_bubble(rs_need, rt_need);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush FSM with bubble counter, memory freeze and saturating perf counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 3,
  parameter int FORWARD_EN  = 1,
  parameter int RF_BYPASS   = 1,
  parameter int ZERO_REG_EN = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic              id_rs_vld,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rt_vld,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wr_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wr_en,
  input  logic              flush_req,
  input  logic              mem_stall,
  output logic              pc_hold,
  output logic              fd_hold,
  output logic              de_nop,
  output logic              fd_flush,
  output logic              de_flush,
  output logic              freeze,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  state_e           state_q, state_d;
  bubble_t          cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  bubble_t          bubbles;
  logic             stall_act;
  logic             flush_act;

  hazard_dist #(
    .REG_AW      (REG_AW),
    .FORWARD_EN  (FORWARD_EN),
    .RF_BYPASS   (RF_BYPASS),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_dist (
    .id_rs_i      (id_rs),
    .id_rs_vld_i  (id_rs_vld),
    .id_rt_i      (id_rt),
    .id_rt_vld_i  (id_rt_vld),
    .ex_rd_i      (ex_rd),
    .ex_wr_en_i   (ex_wr_en),
    .ex_is_load_i (ex_is_load),
    .mem_rd_i     (mem_rd),
    .mem_wr_en_i  (mem_wr_en),
    .wb_rd_i      (wb_rd),
    .wb_wr_en_i   (wb_wr_en),
    .bubbles_o    (bubbles)
  );

  // cnt_q holds the stall cycles still owed after the current one; nonzero only in STALL
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_act = 1'b0;
    flush_act = 1'b0;
    if (!mem_stall) begin
      if (flush_req) begin
        flush_act = 1'b1;
        state_d   = RUN;
        cnt_d     = '0;
      end else if (state_q == STALL) begin
        stall_act = 1'b1;
        if (cnt_q == 2'd1) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end else if (bubbles != '0) begin
        stall_act = 1'b1;
        cnt_d     = bubbles - 2'd1;
        state_d   = (bubbles > 2'd1) ? STALL : RUN;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_act && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_act && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_hold      = stall_act;
  assign fd_hold      = stall_act;
  assign de_nop       = stall_act;
  assign fd_flush     = flush_act;
  assign de_flush     = flush_act;
  assign freeze       = mem_stall;
  assign busy         = (state_q == STALL);
  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - four parameterisations of hazard_ctrl on shared stimulus against a pending-bubble model
module tb_hazard_ctrl;

  localparam int N = 4;
  // dut: 0 fwd, 1 no-fwd+bypass, 2 no-fwd no-bypass, 3 no-fwd no-bypass zero-reg CNT_W=2
  localparam logic [N-1:0] P_FWD = 4'b0001;
  localparam logic [N-1:0] P_BYP = 4'b0011;
  localparam logic [N-1:0] P_ZR  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic       id_rs_vld, id_rt_vld, ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en;
  logic       flush_req, mem_stall;

  logic        pc_hold[N], fd_hold[N], de_nop[N], fd_flush[N], de_flush[N], freeze[N], busy[N];
  logic [15:0] stall_cycles[3], flush_events[3];
  logic [1:0]  sc_w2, fe_w2;

  int pend[N], sc[N], fe[N];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(
      .REG_AW(3), .FORWARD_EN(int'(P_FWD[g])), .RF_BYPASS(int'(P_BYP[g])),
      .ZERO_REG_EN(int'(P_ZR[g])), .CNT_W(16)
    ) u_dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
      .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_wr_en(mem_wr_en),
      .wb_rd(wb_rd), .wb_wr_en(wb_wr_en), .flush_req(flush_req), .mem_stall(mem_stall),
      .pc_hold(pc_hold[g]), .fd_hold(fd_hold[g]), .de_nop(de_nop[g]), .fd_flush(fd_flush[g]),
      .de_flush(de_flush[g]), .freeze(freeze[g]), .busy(busy[g]),
      .stall_cycles(stall_cycles[g]), .flush_events(flush_events[g])
    );
  end

  hazard_ctrl #(
    .REG_AW(3), .FORWARD_EN(0), .RF_BYPASS(0), .ZERO_REG_EN(1), .CNT_W(2)
  ) u_dut3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt), .id_rt_vld(id_rt_vld),
    .ex_rd(ex_rd), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .mem_rd(mem_rd), .mem_wr_en(mem_wr_en),
    .wb_rd(wb_rd), .wb_wr_en(wb_wr_en), .flush_req(flush_req), .mem_stall(mem_stall),
    .pc_hold(pc_hold[3]), .fd_hold(fd_hold[3]), .de_nop(de_nop[3]), .fd_flush(fd_flush[3]),
    .de_flush(de_flush[3]), .freeze(freeze[3]), .busy(busy[3]),
    .stall_cycles(sc_w2), .flush_events(fe_w2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hit(int k, logic [2:0] src, logic [2:0] dst, logic en);
    return en && (src == dst) && !(P_ZR[k] && dst == 3'd0);
  endfunction

  // A result is readable 'avail' stages after issue; bubbles = avail - producer distance
  function automatic int src_need(int k, logic [2:0] src, logic vld);
    int best = 0;
    int avail;
    avail = P_BYP[k] ? 3 : 4;
    if (!vld) return 0;
    if (P_FWD[k]) return (hit(k, src, ex_rd, ex_wr_en) && ex_is_load) ? 1 : 0;
    if (hit(k, src, wb_rd, wb_wr_en))   best = avail - 3;
    if (hit(k, src, mem_rd, mem_wr_en)) best = avail - 2;
    if (hit(k, src, ex_rd, ex_wr_en))   best = avail - 1;
    return best;
  endfunction

  function automatic int need(int k);
    int a, b;
    a = src_need(k, id_rs, id_rs_vld);
    b = src_need(k, id_rt, id_rt_vld);
    return (a > b) ? a : b;
  endfunction

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      int n, sat;
      logic st, fl, bsy;
      logic [31:0] got_sc, got_fe;
      sat = (k == 3) ? 3 : 65535;
      n   = need(k);
      bsy = pend[k] > 0;
      st  = 1'b0;
      fl  = 1'b0;
      if (!mem_stall) begin
        if (flush_req)        fl = 1'b1;
        else if (pend[k] > 0) st = 1'b1;
        else if (n > 0)       st = 1'b1;
      end
      got_sc = (k == 3) ? 32'(sc_w2) : 32'(stall_cycles[k]);
      got_fe = (k == 3) ? 32'(fe_w2) : 32'(flush_events[k]);
      if (!rst) begin
        check($sformatf("ctrl%0d", k),
              {pc_hold[k], fd_hold[k], de_nop[k], fd_flush[k], de_flush[k], freeze[k], busy[k]},
              {st, st, st, fl, fl, mem_stall, bsy});
        check($sformatf("stall_cycles%0d", k), got_sc, sc[k]);
        check($sformatf("flush_events%0d", k), got_fe, fe[k]);
      end
      if (rst) begin
        pend[k] = 0; sc[k] = 0; fe[k] = 0;
      end else if (fl) begin
        pend[k] = 0;
        if (fe[k] < sat) fe[k]++;
      end else if (st) begin
        if (sc[k] < sat) sc[k]++;
        if (pend[k] > 0) pend[k]--;
        else pend[k] = n - 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    id_rs_vld = 0; id_rt_vld = 0; ex_wr_en = 0; ex_is_load = 0;
    mem_wr_en = 0; wb_wr_en = 0; flush_req = 0; mem_stall = 0;
  endtask

  task automatic drain(int cycles);
    idle();
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin pend[k] = 0; sc[k] = 0; fe[k] = 0; end
    rst = 1'b1;
    idle();
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;
    step();

    // load-use with forwarding, then the same without a load
    ex_rd = 3; ex_wr_en = 1; ex_is_load = 1; id_rs = 3; id_rs_vld = 1;
    step(); drain(4);
    check("fwd_load_total", 32'(stall_cycles[0]), 1);
    ex_rd = 3; ex_wr_en = 1; ex_is_load = 0; id_rs = 3; id_rs_vld = 1;
    step(); drain(4);
    check("fwd_alu_total", 32'(stall_cycles[0]), 1);

    // EX on rt, MEM-only, WB-only
    ex_rd = 5; ex_wr_en = 1; id_rt = 5; id_rt_vld = 1;
    step(); drain(4);
    mem_rd = 2; mem_wr_en = 1; id_rs = 2; id_rs_vld = 1;
    step(); drain(4);
    wb_rd = 6; wb_wr_en = 1; id_rt = 6; id_rt_vld = 1;
    step(); drain(4);

    // hazard held two cycles then dropped mid-stall
    ex_rd = 4; ex_wr_en = 1; id_rs = 4; id_rs_vld = 1;
    step(); step(); drain(4);

    // flush in first stall cycle, then flush together with a new hazard
    ex_rd = 1; ex_wr_en = 1; id_rs = 1; id_rs_vld = 1;
    step(); idle(); flush_req = 1; step(); drain(3);
    check("flush_once", 32'(flush_events[2]), 1);
    ex_rd = 7; ex_wr_en = 1; id_rt = 7; id_rt_vld = 1; flush_req = 1;
    step(); drain(4);

    // memory freeze inside a stall
    ex_rd = 2; ex_wr_en = 1; id_rt = 2; id_rt_vld = 1;
    step(); idle(); mem_stall = 1;
    for (int i = 0; i < 4; i++) step();
    drain(4);

    // r0 dependency, then saturation of the narrow counter
    ex_rd = 0; ex_wr_en = 1; id_rs = 0; id_rs_vld = 1;
    step(); drain(4);
    for (int i = 0; i < 5; i++) begin
      ex_rd = 3; ex_wr_en = 1; id_rs = 3; id_rs_vld = 1;
      step(); drain(4);
    end
    check("narrow_saturated", 32'(sc_w2), 3);

    // reset while stalled and frozen
    ex_rd = 5; ex_wr_en = 1; id_rs = 5; id_rs_vld = 1;
    step(); idle(); rst = 1; mem_stall = 1; step();
    rst = 0; mem_stall = 0; step();
    check("post_rst_busy", 32'(busy[2]), 0);

    for (int i = 0; i < 3000; i++) begin
      id_rs = 3'($urandom_range(0, 3)); id_rt = 3'($urandom_range(0, 3));
      ex_rd = 3'($urandom_range(0, 3)); mem_rd = 3'($urandom_range(0, 3)); wb_rd = 3'($urandom_range(0, 3));
      id_rs_vld = 1'($urandom); id_rt_vld = 1'($urandom);
      ex_wr_en = 1'($urandom); ex_is_load = 1'($urandom);
      mem_wr_en = 1'($urandom); wb_wr_en = 1'($urandom);
      flush_req = ($urandom_range(0, 15) == 0);
      mem_stall = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0;
    drain(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
